// File: rtl/matrix_tile_sequencer.sv
// Matrix tile sequencer: walks the A/B tile grid, issues operand reads to the
// MAC array and steers the returning result beats to output addresses.
module matrix_tile_sequencer #(
   parameter int ROW_SIZE        = 8,
   parameter int COLUMN_SIZE     = 8,
   parameter int CTRL_N_LEN      = 12,
   parameter int ADDR_A_LEN      = 12,
   parameter int ADDR_B_LEN      = 12,
   parameter int ADDR_OUTPUT_LEN = 12,
   parameter int BRAM_DELAY      = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [ADDR_A_LEN-1:0]      cmd_a_size,
   input  logic [ADDR_B_LEN-1:0]      cmd_b_size,
   input  logic [CTRL_N_LEN-1:0]      cmd_n_size,
   input  logic                       cmd_acc,
   output logic [ADDR_A_LEN-1:0]      a_addr,
   output logic [ADDR_B_LEN-1:0]      b_addr,
   output logic                       rd_en,
   output logic                       mac_start,
   output logic [CTRL_N_LEN-1:0]      mac_num,
   input  logic                       res_valid,
   output logic [ADDR_OUTPUT_LEN-1:0] output_addr,
   output logic                       output_we,
   output logic                       output_acc,
   output logic                       done,
   output logic                       err
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   localparam int BW  = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
   localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OCW = PW + 1;
   localparam int CSH = $clog2(COLUMN_SIZE);
   localparam int OW  = ADDR_OUTPUT_LEN;

   // The row count only sizes the MAC datapath; the sequencer itself is row-agnostic.
   if (ROW_SIZE < 1) begin : g_no_rows
   end

   state_t                state;
   logic [ADDR_A_LEN-1:0] a_len, ai;
   logic [ADDR_B_LEN-1:0] b_len, bi;
   logic [CTRL_N_LEN-1:0] n_len, k;
   logic                  acc, all_issued;
   logic [OW-1:0]         row_base, beat_off;
   logic [OCW-1:0]        outstanding;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [BW-1:0]         beat;
   logic [OW-1:0]         fifo_mem [MAX_OUTSTANDING];
   logic [BRAM_DELAY-1:0] mac_dly;
   logic                  res_ok, last_beat, tile_end, space, start, zero_cmd;

   assign res_ok      = res_valid && (outstanding != '0);
   assign last_beat   = res_ok && (beat == BW'(COLUMN_SIZE - 1));
   assign tile_end    = !rd_en || (k == n_len - CTRL_N_LEN'(1));
   // A completing tile frees its slot in the same cycle a new one may claim it.
   assign space       = (outstanding != OCW'(MAX_OUTSTANDING)) || last_beat;
   assign start       = (state == ISSUE) && tile_end && !all_issued && space;
   assign zero_cmd    = (cmd_a_size == '0) || (cmd_b_size == '0) || (cmd_n_size == '0);

   assign cmd_ready   = (state == IDLE);
   assign output_we   = res_ok;
   assign output_addr = res_ok ? (fifo_mem[rd_ptr] + beat_off) : '0;
   assign output_acc  = acc;
   assign mac_start   = mac_dly[BRAM_DELAY-1];
   assign mac_num     = n_len;

   // Output-base FIFO storage; entries are only consumed while tiles are outstanding.
   always_ff @(posedge clk) begin
      if (start) fifo_mem[wr_ptr] <= row_base + OW'(bi);
   end

   // Command FSM, read address generation, outstanding tracking and beat steering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a_len       <= '0;
         b_len       <= '0;
         n_len       <= '0;
         acc         <= 1'b0;
         ai          <= '0;
         bi          <= '0;
         k           <= '0;
         all_issued  <= 1'b0;
         row_base    <= '0;
         rd_en       <= 1'b0;
         a_addr      <= '0;
         b_addr      <= '0;
         mac_dly     <= '0;
         outstanding <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         beat        <= '0;
         beat_off    <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;

         if (res_valid && (outstanding == '0)) err <= 1'b1;
         else if (cmd_valid && (state == IDLE)) err <= 1'b0;

         if (start && !last_beat) outstanding <= outstanding + OCW'(1);
         else if (!start && last_beat) outstanding <= outstanding - OCW'(1);

         if (last_beat) begin
            beat     <= '0;
            beat_off <= '0;
            rd_ptr   <= rd_ptr + PW'(1);
         end else if (res_ok) begin
            beat     <= beat + BW'(1);
            beat_off <= beat_off + OW'(b_len);
         end

         mac_dly[0] <= rd_en && (k == '0);
         for (int i = 1; i < BRAM_DELAY; i++) mac_dly[i] <= mac_dly[i-1];

         case (state)
            IDLE: begin
               rd_en <= 1'b0;
               if (cmd_valid) begin
                  a_len      <= cmd_a_size;
                  b_len      <= cmd_b_size;
                  n_len      <= cmd_n_size;
                  acc        <= cmd_acc;
                  ai         <= '0;
                  bi         <= '0;
                  k          <= '0;
                  row_base   <= '0;
                  all_issued <= 1'b0;
                  state      <= zero_cmd ? DRAIN : ISSUE;
               end
            end
            ISSUE: begin
               if (!tile_end) begin
                  a_addr <= a_addr + a_len;
                  b_addr <= b_addr + b_len;
                  k      <= k + CTRL_N_LEN'(1);
               end else if (all_issued) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else if (space) begin
                  rd_en  <= 1'b1;
                  a_addr <= ai;
                  b_addr <= bi;
                  k      <= '0;
                  wr_ptr <= wr_ptr + PW'(1);
                  if (bi == b_len - ADDR_B_LEN'(1)) begin
                     bi       <= '0;
                     row_base <= row_base + (OW'(b_len) << CSH);
                     if (ai == a_len - ADDR_A_LEN'(1)) all_issued <= 1'b1;
                     else ai <= ai + ADDR_A_LEN'(1);
                  end else begin
                     bi <= bi + ADDR_B_LEN'(1);
                  end
               end else begin
                  rd_en <= 1'b0;
               end
            end
            DRAIN: begin
               rd_en <= 1'b0;
               if (outstanding == '0) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               rd_en <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_tile_sequencer.sv
// Scoreboard bench for matrix_tile_sequencer: expected reads/writes are queued
// when a command is issued and checked as the DUT produces them.
module tb_matrix_tile_sequencer;

   localparam int CS = 8;
   localparam int BD = 1;

   logic        clk;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [11:0] cmd_a_size = 12'd0;
   logic [11:0] cmd_b_size = 12'd0;
   logic [11:0] cmd_n_size = 12'd0;
   logic        cmd_acc = 1'b0;
   logic [11:0] a_addr, b_addr, mac_num, output_addr;
   logic        rd_en, mac_start, output_we, output_acc, done, err;
   logic        res_valid = 1'b0;

   logic clr = 1'b0;
   logic res_en = 1'b1;
   logic stray = 1'b0;

   int n_pass = 0;
   int n_chk = 0;
   int cyc = 0;
   int rd_count = 0, wr_count = 0, mac_seen = 0, done_cnt = 0;
   int cyc_r5 = -1, cyc_w8 = -1, done_cyc = -1;
   int beats_sent = 0;
   int acc_cyc = 0;
   int exp_n = 0;
   int rq[$];
   int wq[$];
   int mq[$];

   matrix_tile_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a_size(cmd_a_size), .cmd_b_size(cmd_b_size), .cmd_n_size(cmd_n_size),
      .cmd_acc(cmd_acc), .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en),
      .mac_start(mac_start), .mac_num(mac_num), .res_valid(res_valid),
      .output_addr(output_addr), .output_we(output_we), .output_acc(output_acc),
      .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Result driver: returns CS beats for every mac_start seen, plus forced stray beats.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (clr || rst) beats_sent = 0;
         if (stray) begin
            res_valid = 1'b1;
         end else if (res_en && !rst && !clr && (mac_seen * CS > beats_sent)) begin
            res_valid = 1'b1;
            beats_sent++;
         end else begin
            res_valid = 1'b0;
         end
      end
   end

   // Monitor: compares DUT activity against the queued expectations.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (clr) begin
            rq.delete(); wq.delete(); mq.delete();
            rd_count = 0; wr_count = 0; mac_seen = 0; done_cnt = 0;
            cyc_r5 = -1; cyc_w8 = -1; done_cyc = -1;
         end else if (!rst) begin
            if (rd_en) begin
               rd_count++;
               if (rd_count == 5) cyc_r5 = cyc;
               if (rq.size() == 0) check("rd_extra", int'({a_addr, b_addr}), -1);
               else begin
                  e = rq.pop_front();
                  check("rd_addr", int'({a_addr, b_addr}), e & 32'h00FF_FFFF);
                  if (e[24]) mq.push_back(cyc + BD);
               end
            end
            if (mac_start) begin
               mac_seen++;
               check("mac_num", int'(mac_num), exp_n);
               if (mq.size() == 0) check("mac_extra", cyc, -1);
               else check("mac_cyc", cyc, mq.pop_front());
            end
            if (output_we) begin
               wr_count++;
               if (wr_count == 8) cyc_w8 = cyc;
               if (wq.size() == 0) check("wr_extra", int'({output_acc, output_addr}), -1);
               else check("wr_addr_acc", int'({output_acc, output_addr}), wq.pop_front());
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic start_cmd(input int a, input int b, input int n, input int acc, input bit release_rst);
      int base;
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1 clr = 1'b0;
      exp_n = n;
      if (n > 0) begin
         for (int ai = 0; ai < a; ai++) begin
            for (int bi = 0; bi < b; bi++) begin
               base = (ai * CS * b + bi) % 4096;
               for (int k = 0; k < n; k++)
                  rq.push_back(((k == 0) ? (1 << 24) : 0) | (((ai + k * a) % 4096) << 12)
                               | ((bi + k * b) % 4096));
               for (int j = 0; j < CS; j++)
                  wq.push_back((acc << 12) | ((base + j * b) % 4096));
            end
         end
      end
      if (release_rst) rst = 1'b0;
      check("idle_ready", int'(cmd_ready), 1);
      cmd_a_size = 12'(a);
      cmd_b_size = 12'(b);
      cmd_n_size = 12'(n);
      cmd_acc    = acc[0];
      cmd_valid  = 1'b1;
      acc_cyc    = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check("accepted", int'(cmd_ready), 0);
      check("accept_err", int'(err), 0);
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while (done_cnt == 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_done_seen"}, int'(done_cnt != 0), 1);
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_rd_left"}, rq.size(), 0);
      check({tag, "_wr_left"}, wq.size(), 0);
      check({tag, "_mac_left"}, mq.size(), 0);
   endtask

   initial begin
      int t;
      #12;
      check("rst_cmd_ready", int'(cmd_ready), 1);
      check("rst_rd_en", int'(rd_en), 0);
      check("rst_we", int'(output_we), 0);
      check("rst_done_err", int'({done, err, mac_start}), 0);
      check("rst_addrs", int'({a_addr, b_addr, output_addr}), 0);

      start_cmd(1, 1, 3, 0, 1'b1);
      wait_done("basic");
      check("basic_writes", wr_count, 8);

      start_cmd(2, 3, 2, 0, 1'b0);
      wait_done("order");
      check("order_writes", wr_count, 48);

      res_en = 1'b0;
      start_cmd(1, 6, 1, 0, 1'b0);
      repeat (30) @(negedge clk);
      check("bp_issued", rd_count, 4);
      check("bp_stall", int'(rd_en), 0);
      res_en = 1'b1;
      wait_done("bp");
      check("bp_refill", cyc_r5 - cyc_w8, 1);

      start_cmd(3, 2, 0, 0, 1'b0);
      wait_done("zero");
      check("zero_latency", done_cyc - acc_cyc, 2);
      check("zero_reads", rd_count, 0);
      check("zero_mac", mac_seen, 0);

      @(negedge clk);
      #1 stray = 1'b1;
      @(posedge clk);
      #2 stray = 1'b0;
      @(negedge clk);
      check("stray_driven", int'(res_valid), 1);
      check("stray_we", int'(output_we), 0);
      @(negedge clk);
      check("stray_err", int'(err), 1);
      start_cmd(1, 2, 2, 1, 1'b0);
      wait_done("acc");

      start_cmd(2, 2, 4, 0, 1'b0);
      t = 0;
      while (rd_count < 5 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("midrst_reached", int'(rd_count >= 5), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_cmd_ready", int'(cmd_ready), 1);
      check("midrst_rd_en", int'(rd_en), 0);
      check("midrst_we", int'(output_we), 0);
      check("midrst_done_err_mac", int'({done, err, mac_start}), 0);
      check("midrst_addrs", int'({a_addr, b_addr, output_addr}), 0);
      start_cmd(1, 2, 2, 0, 1'b1);
      wait_done("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/matrix_tile_sequencer.md
MATRIX_TILE_SEQUENCER -- requirements
Module: matrix_tile_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ROW_SIZE, 8, MAC array rows, one output word per row per beat.
- COLUMN_SIZE, 8, result beats per tile; power of two.
- CTRL_N_LEN, 12, width of the inner-dimension count.
- ADDR_A_LEN, 12, A address width.
- ADDR_B_LEN, 12, B address width.
- ADDR_OUTPUT_LEN, 12, output address width.
- BRAM_DELAY, 1, read latency in cycles, >=1.
- MAX_OUTSTANDING, 4, maximum tiles issued but not yet written back; power of two, >=2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, reset: asynchronous, active-high.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, block idle and able to accept a command.
- cmd_a_size, in, ADDR_A_LEN, A tile count.
- cmd_b_size, in, ADDR_B_LEN, B tile count.
- cmd_n_size, in, CTRL_N_LEN, inner length.
- cmd_acc, in, 1, 1 = accumulate into output, 0 = overwrite.
- a_addr, out, ADDR_A_LEN, A read address.
- b_addr, out, ADDR_B_LEN, B read address.
- rd_en, out, 1, read strobe.
- mac_start, out, 1, first operand of a tile reaches the MAC array.
- mac_num, out, CTRL_N_LEN, inner length for that tile.
- res_valid, in, 1, one result beat from the MAC array.
- output_addr, out, ADDR_OUTPUT_LEN, write address.
- output_we, out, 1, write strobe.
- output_acc, out, 1, accumulate qualifier for this write.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, sticky protocol error.

Function
REQ-003 The state machine SHALL have three states, IDLE, ISSUE and DRAIN; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On cmd_valid&cmd_ready the block SHALL latch all sizes and cmd_acc, clear err, and enter ISSUE.
- If any size is 0, it SHALL go straight to DRAIN with no reads issued.
REQ-005 Tile order SHALL be b index inner (0..b_size-1) and a index outer (0..a_size-1).
REQ-006 Each tile SHALL take n_size consecutive read cycles with rd_en=1. For k = 0..n-1:
- a_addr = ai + k*a_size;
- b_addr = bi + k*b_size;
- all sums SHALL be modulo the port width.
REQ-007 A new tile SHALL start only when outstanding < MAX_OUTSTANDING.
- Otherwise rd_en SHALL be 0 and the addresses held until space frees.
- The next tile SHALL start on the cycle after the previous tile's last read when space exists.
REQ-008 mac_start SHALL pulse exactly BRAM_DELAY cycles after a tile's first read cycle, with mac_num = n_size.
REQ-009 At each tile start the block SHALL push the output base into a MAX_OUTSTANDING-deep FIFO. The base SHALL be ai*COLUMN_SIZE*b_size + bi, truncated to ADDR_OUTPUT_LEN.
REQ-010 The outstanding count SHALL increment on tile start and decrement on the COLUMN_SIZE-th res_valid beat of a tile.
- If both happen in the same cycle, the count SHALL be unchanged.
REQ-011 output_we SHALL equal res_valid combinationally.
- output_addr = FIFO head + beat*b_size, where beat = 0..COLUMN_SIZE-1.
- output_acc SHALL equal the latched cmd_acc.
- On the last beat the FIFO head SHALL pop and beat SHALL return to 0.
REQ-012 After the last read of the last tile the block SHALL move ISSUE -> DRAIN.
REQ-013 In DRAIN with outstanding==0 the block SHALL pulse done for one cycle and return to IDLE in that same cycle.
REQ-014 A res_valid arriving while outstanding==0 SHALL be suppressed (output_we=0) and SHALL set err; err SHALL hold until the next command is accepted.
REQ-015 A cmd_valid arriving outside IDLE SHALL be ignored.

Reset
REQ-016 Asserting rst at any time, including mid-tile, SHALL asynchronously force the following, and SHALL discard all pending FIFO entries:
- state = IDLE, so cmd_ready = 1;
- rd_en, mac_start, output_we, done, err = 0;
- outstanding, beat, FIFO pointers = 0;
- a_addr, b_addr, output_addr = 0.
REQ-017 The block SHALL accept a command on the first rising edge after rst deasserts.

Verification
REQ-018 Scenario "basic 1x1 tile":
- Stimulus: command a=1, b=1, n=3, acc=0, then 8 res_valid beats 5 cycles later.
- Required: rd_en for 3 cycles; a_addr 0,1,2; b_addr 0,1,2; mac_start BRAM_DELAY cycles after the first read.
- Required: writes to addresses 0..7 with output_acc=0; then done for 1 cycle.
REQ-019 Scenario "2x3 tile order":
- Stimulus: a=2, b=3, n=2.
- Required: tile bases 0, 1, 2, 24, 25, 26.
- Required: tile (1,2) writes addresses 26, 29, ..., 47.
REQ-020 Scenario "back-pressure":
- Stimulus: a=1, b=6, n=1, res_valid withheld.
- Required: exactly 4 tiles issued, then rd_en stalls.
- Required: after the first tile's 8 beats, tile 5 issues on the next cycle.
REQ-021 Scenario "zero size":
- Stimulus: n=0.
- Required: no rd_en and no mac_start; done 2 cycles after acceptance.
REQ-022 Scenario "stray result and accumulate":
- Stimulus: res_valid while idle, then a command with acc=1.
- Required: err=1 and no write while idle; err clears on acceptance; all writes carry output_acc=1.
REQ-023 Scenario "reset mid-operation":
- Stimulus: rst asserted during the ISSUE read of tile 2.
- Required: all outputs return to their REQ-016 values immediately, cmd_ready=1, and the following command runs correctly.
